// File: rtl/sm83_fetch_unit_pkg.sv
// Shared types and constants for the SM83 opcode/immediate fetch sequencer.
package sm83_fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_OP,
        ST_FETCH_CB,
        ST_HANDOFF,
        ST_IMM_LO,
        ST_IMM_HI,
        ST_HALTED
    } fetch_state_t;

    typedef logic [1:0] imm_cnt_t;

    localparam logic [7:0] CB_PREFIX = 8'hCB;

    function automatic logic is_fetch_state(input fetch_state_t s);
        return (s == ST_FETCH_OP) || (s == ST_FETCH_CB) || (s == ST_IMM_LO) || (s == ST_IMM_HI);
    endfunction

endpackage

// File: rtl/sm83_fetch_unit.sv
// SM83 fetch sequencer: fetch_go -> op_valid in 2 cycles at zero wait; memory stalls hold mem_addr, decoder stalls hold op_valid.
// SM83_FETCH_STATS_EN adds saturating stat_ops/stat_wait counters.
module sm83_fetch_unit
    import sm83_fetch_unit_pkg::*;
#(
    parameter bit START_ON_RESET = 1'b1,
    parameter int STAT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_mem_req,
    output logic [15:0]      o_mem_addr,
    input  logic             i_mem_ack,
    input  logic [7:0]       i_mem_rdata,
    input  logic [15:0]      i_r_pc,
    output logic [15:0]      o_w_pc,
    output logic             o_wen_pc,
    output logic [7:0]       o_w_ir,
    output logic             o_wen_ir,
    output logic             o_op_valid,
    input  logic             i_op_ready,
    output logic             o_op_cb,
    input  imm_cnt_t         i_op_imm_cnt,
    output logic             o_imm_valid,
    output logic [15:0]      o_imm16,
    input  logic             i_fetch_go,
    input  logic             i_flush,
    input  logic             i_halt_req,
    input  logic             i_wake,
    output logic             o_halted
`ifdef SM83_FETCH_STATS_EN
    ,
    output logic [STAT_W-1:0] o_stat_ops,
    output logic [STAT_W-1:0] o_stat_wait
`endif
);

    fetch_state_t r_state;
    logic         r_pending;
    logic         r_cb;
    logic         r_imm_two;
    logic         r_imm_valid;
    logic [15:0]  r_imm16;

    logic w_in_fetch;
    logic w_take;
    logic w_ir_write;

    assign w_in_fetch = is_fetch_state(r_state);
    // An ack that coincides with flush or reset is dropped so the register file never sees it.
    assign w_take     = w_in_fetch & i_mem_ack & ~i_flush & ~i_rst;
    assign w_ir_write = w_take & (((r_state == ST_FETCH_OP) & (i_mem_rdata != CB_PREFIX))
                                  | (r_state == ST_FETCH_CB));

    assign o_mem_req   = w_in_fetch;
    assign o_mem_addr  = w_in_fetch ? i_r_pc : 16'h0000;
    assign o_wen_pc    = w_take;
    assign o_w_pc      = w_take ? (i_r_pc + 16'd1) : 16'h0000;
    assign o_wen_ir    = w_ir_write;
    assign o_w_ir      = w_ir_write ? i_mem_rdata : 8'h00;
    assign o_op_valid  = (r_state == ST_HANDOFF);
    assign o_op_cb     = r_cb;
    assign o_imm_valid = r_imm_valid;
    assign o_imm16     = r_imm16;
    assign o_halted    = (r_state == ST_HALTED);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_pending   <= START_ON_RESET;
            r_cb        <= 1'b0;
            r_imm_two   <= 1'b0;
            r_imm_valid <= 1'b0;
            r_imm16     <= 16'h0000;
        end else begin
            r_imm_valid <= 1'b0;
            if (i_flush) begin
                r_state <= ST_IDLE;
                r_cb    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_halt_req) begin
                            r_state <= ST_HALTED;
                        end else if (i_fetch_go || r_pending) begin
                            r_state   <= ST_FETCH_OP;
                            r_pending <= 1'b0;
                            r_cb      <= 1'b0;
                            r_imm16   <= 16'h0000;
                        end
                    end
                    ST_FETCH_OP: begin
                        if (i_mem_ack) begin
                            if (i_mem_rdata == CB_PREFIX) begin
                                r_state <= ST_FETCH_CB;
                                r_cb    <= 1'b1;
                            end else begin
                                r_state <= ST_HANDOFF;
                            end
                        end
                    end
                    ST_FETCH_CB: begin
                        if (i_mem_ack) begin
                            r_state <= ST_HANDOFF;
                        end
                    end
                    ST_HANDOFF: begin
                        if (i_op_ready) begin
                            if (i_op_imm_cnt == 2'd0) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_imm_two <= i_op_imm_cnt[1];
                                r_state   <= ST_IMM_LO;
                            end
                        end
                    end
                    ST_IMM_LO: begin
                        if (i_mem_ack) begin
                            r_imm16 <= {8'h00, i_mem_rdata};
                            if (r_imm_two) begin
                                r_state <= ST_IMM_HI;
                            end else begin
                                r_state     <= ST_IDLE;
                                r_imm_valid <= 1'b1;
                            end
                        end
                    end
                    ST_IMM_HI: begin
                        if (i_mem_ack) begin
                            r_imm16[15:8] <= i_mem_rdata;
                            r_state       <= ST_IDLE;
                            r_imm_valid   <= 1'b1;
                        end
                    end
                    ST_HALTED: begin
                        if (i_wake) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SM83_FETCH_STATS_EN
    logic [STAT_W-1:0] r_stat_ops;
    logic [STAT_W-1:0] r_stat_wait;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_ops  <= '0;
            r_stat_wait <= '0;
        end else begin
            if ((r_state == ST_HANDOFF) && i_op_ready && !i_flush && !(&r_stat_ops)) begin
                r_stat_ops <= r_stat_ops + 1'b1;
            end
            if (w_in_fetch && !i_mem_ack && !(&r_stat_wait)) begin
                r_stat_wait <= r_stat_wait + 1'b1;
            end
        end
    end

    assign o_stat_ops  = r_stat_ops;
    assign o_stat_wait = r_stat_wait;
`else
    logic w_unused_stat_w;
    assign w_unused_stat_w = (STAT_W > 0);
`endif

endmodule

// File: tb/tb_sm83_fetch_unit.sv
// Scoreboard bench for sm83_fetch_unit: memory/register-file models drive the DUT, a monitor checks every PC/IR write, handoff and immediate.
module tb_sm83_fetch_unit;

    typedef struct {
        logic [15:0] a;
        int          w;
        logic [1:0]  cnt;
        logic [31:0] bytes;
        logic        cb;
        logic [7:0]  ir;
        int          n;
        logic        has_imm;
        logic [15:0] imm;
        int          stall;
        bit          lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        ack;
    logic [7:0]  rdata;
    logic [15:0] pc;
    logic [15:0] w_pc;
    logic        wen_pc;
    logic [7:0]  w_ir;
    logic        wen_ir;
    logic        op_valid;
    logic        op_ready;
    logic        op_cb;
    logic [1:0]  imm_cnt;
    logic        imm_valid;
    logic [15:0] imm16;
    logic        go;
    logic        flush;
    logic        halt_req;
    logic        wake;
    logic        halted;
`ifdef SM83_FETCH_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_wait;
`endif

    logic [7:0]  mem [0:65535];
    int          wait_cfg;
    bit          resp_en;
    int          wcnt;
    int          errors;
    int          checks;

    logic [15:0] q_pc[$];
    logic [7:0]  q_ir[$];
    logic        q_cb[$];
    logic [15:0] q_imm[$];

    vec_t vecs[8];

    sm83_fetch_unit #(.START_ON_RESET(1'b0), .STAT_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_ack    (ack),
        .i_mem_rdata  (rdata),
        .i_r_pc       (pc),
        .o_w_pc       (w_pc),
        .o_wen_pc     (wen_pc),
        .o_w_ir       (w_ir),
        .o_wen_ir     (wen_ir),
        .o_op_valid   (op_valid),
        .i_op_ready   (op_ready),
        .o_op_cb      (op_cb),
        .i_op_imm_cnt (imm_cnt),
        .o_imm_valid  (imm_valid),
        .o_imm16      (imm16),
        .i_fetch_go   (go),
        .i_flush      (flush),
        .i_halt_req   (halt_req),
        .i_wake       (wake),
        .o_halted     (halted)
`ifdef SM83_FETCH_STATS_EN
        ,
        .o_stat_ops   (stat_ops),
        .o_stat_wait  (stat_wait)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen with nothing expected", name);
    endtask

    function automatic vec_t mk(input logic [15:0] a, input int w, input logic [1:0] cnt,
                                input logic [31:0] bytes, input logic cb, input logic [7:0] ir,
                                input int n, input logic has_imm, input logic [15:0] imm,
                                input int stall, input bit lat);
        vec_t v;
        v.a = a; v.w = w; v.cnt = cnt; v.bytes = bytes; v.cb = cb; v.ir = ir;
        v.n = n; v.has_imm = has_imm; v.imm = imm; v.stall = stall; v.lat = lat;
        return v;
    endfunction

    // Register-file PC and memory responder.
    initial begin
        logic        pw;
        logic [15:0] pv;
        forever begin
            @(negedge clk);
            pw = wen_pc;
            pv = w_pc;
            @(posedge clk);
            #1;
            if (pw) pc = pv;
            #1;
            if (resp_en) begin
                if (mem_req) begin
                    chk("mem_addr", mem_addr, pc);
                    if (wcnt < wait_cfg) begin
                        wcnt++;
                        ack = 1'b0;
                    end else begin
                        wcnt  = 0;
                        ack   = 1'b1;
                        rdata = mem[pc];
                    end
                end else begin
                    wcnt = 0;
                    ack  = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wen_pc) begin
                    if (q_pc.size() == 0) unexpected("pc_write");
                    else chk("w_pc", w_pc, q_pc.pop_front());
                end
                if (wen_ir) begin
                    if (q_ir.size() == 0) unexpected("ir_write");
                    else chk("w_ir", w_ir, q_ir.pop_front());
                end
                if (op_valid && op_ready && !flush) begin
                    if (q_cb.size() == 0) unexpected("op_accept");
                    else chk("op_cb", op_cb, q_cb.pop_front());
                end
                if (imm_valid) begin
                    if (q_imm.size() == 0) unexpected("imm_valid");
                    else chk("imm16", imm16, q_imm.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        go = 1'b0; flush = 1'b0; halt_req = 1'b0; wake = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_fetch();
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q_pc.size() + q_ir.size() + q_cb.size() + q_imm.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((q_pc.size() + q_ir.size() + q_cb.size() + q_imm.size()) != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d events outstanding, expected 0", name,
                     q_pc.size() + q_ir.size() + q_cb.size() + q_imm.size());
            q_pc.delete(); q_ir.delete(); q_cb.delete(); q_imm.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_op_valid(input string name);
        int n = 0;
        while (!op_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, op_valid, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < 4; i++) mem[v.a + 16'(i)] = v.bytes[8*i +: 8];
        for (int i = 1; i <= v.n; i++) q_pc.push_back(v.a + 16'(i));
        q_ir.push_back(v.ir);
        q_cb.push_back(v.cb);
        if (v.has_imm) q_imm.push_back(v.imm);
        pc       = v.a;
        wait_cfg = v.w;
        imm_cnt  = v.cnt;
        op_ready = (v.stall == 0);
        start_fetch();
        if (v.lat) begin
            @(negedge clk);
            chk("lat_c1_mem_req", mem_req, 1'b1);
            chk("lat_c1_op_valid", op_valid, 1'b0);
            @(negedge clk);
            chk("lat_c2_op_valid", op_valid, 1'b1);
        end
        if (v.stall > 0) begin
            wait_op_valid("stall_op_valid");
            for (int i = 0; i < v.stall; i++) begin
                @(negedge clk);
                chk("op_valid_hold", op_valid, 1'b1);
            end
            @(posedge clk);
            #1 op_ready = 1'b1;
        end
        drain("vec");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; ack = 1'b0; rdata = 8'h00; pc = 16'h0000;
        op_ready = 1'b1; imm_cnt = 2'd0; go = 1'b0; flush = 1'b0;
        halt_req = 1'b0; wake = 1'b0; resp_en = 1'b1; wait_cfg = 0; wcnt = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        vecs[0] = mk(16'h0100, 0, 2'd0, 32'h0000_0000, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 0, 1'b1);
        vecs[1] = mk(16'h0200, 3, 2'd0, 32'h0000_37CB, 1'b1, 8'h37, 2, 1'b0, 16'h0000, 0, 1'b0);
        vecs[2] = mk(16'h0300, 0, 2'd2, 32'h0012_34C3, 1'b0, 8'hC3, 3, 1'b1, 16'h1234, 3, 1'b0);
        vecs[3] = mk(16'h0400, 1, 2'd1, 32'h0000_5A3E, 1'b0, 8'h3E, 2, 1'b1, 16'h005A, 0, 1'b0);
        vecs[4] = mk(16'h0500, 2, 2'd3, 32'h00AB_CD01, 1'b0, 8'h01, 3, 1'b1, 16'hABCD, 0, 1'b0);
        vecs[5] = mk(16'hFFFF, 0, 2'd0, 32'h0000_0000, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 0, 1'b0);
        vecs[6] = mk(16'h0600, 0, 2'd0, 32'h0000_CBCB, 1'b1, 8'hCB, 2, 1'b0, 16'h0000, 0, 1'b0);
        vecs[7] = mk(16'hFFFE, 0, 2'd2, 32'h0043_21C3, 1'b0, 8'hC3, 3, 1'b1, 16'h4321, 0, 1'b0);

        do_reset();
        @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_imm_valid", imm_valid, 1'b0);
        chk("rst_imm16", imm16, 16'h0000);
        chk("rst_wen_pc", wen_pc, 1'b0);
        chk("rst_op_cb", op_cb, 1'b0);
        repeat (3) @(negedge clk);
        chk("no_autostart", mem_req, 1'b0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Ack arriving together with flush must be discarded.
        resp_en = 1'b0;
        pc = 16'h0700;
        start_fetch();
        #1;
        ack = 1'b1; rdata = 8'h77; flush = 1'b1;
        @(negedge clk);
        chk("flush_wen_pc", wen_pc, 1'b0);
        chk("flush_wen_ir", wen_ir, 1'b0);
        @(posedge clk);
        #1 ack = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_mem_req", mem_req, 1'b0);
        chk("flush_op_valid", op_valid, 1'b0);
        chk("flush_pc_kept", pc, 16'h0700);
        resp_en = 1'b1;

        // Flush during handoff beats op_ready.
        mem[16'h0710] = 8'h00;
        pc = 16'h0710; wait_cfg = 0; imm_cnt = 2'd0; op_ready = 1'b0;
        q_pc.push_back(16'h0711);
        q_ir.push_back(8'h00);
        start_fetch();
        wait_op_valid("hs_op_valid");
        @(posedge clk);
        #1 flush = 1'b1; op_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("hs_flush_op_valid", op_valid, 1'b0);
        drain("hs_flush");

        // halt_req beats fetch_go in IDLE; fetch_go while halted is ignored.
        @(posedge clk);
        #1 halt_req = 1'b1; go = 1'b1;
        @(posedge clk);
        #1 halt_req = 1'b0; go = 1'b0;
        @(negedge clk);
        chk("halt_halted", halted, 1'b1);
        chk("halt_mem_req", mem_req, 1'b0);
        start_fetch();
        @(negedge clk);
        chk("halt_go_ignored", halted, 1'b1);
        chk("halt_go_no_req", mem_req, 1'b0);
        @(posedge clk);
        #1 wake = 1'b1;
        @(posedge clk);
        #1 wake = 1'b0;
        @(negedge clk);
        chk("wake_halted", halted, 1'b0);
        chk("wake_mem_req", mem_req, 1'b0);
        run_vec(mk(16'h0800, 0, 2'd0, 32'h0000_003C, 1'b0, 8'h3C, 1, 1'b0, 16'h0000, 0, 1'b0));

`ifdef SM83_FETCH_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++)
            run_vec(mk(16'h0900 + 16'(i), 2, 2'd0, 32'h0000_0000, 1'b0, 8'h00, 1, 1'b0,
                       16'h0000, 0, 1'b0));
        chk("stat_ops", stat_ops, 16'd3);
        chk("stat_wait", stat_wait, 16'd6);
        pc = 16'h0A00; wait_cfg = 50;
        start_fetch();
        repeat (3) @(negedge clk);
        chk("stat_req_pending", mem_req, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_req", mem_req, 1'b0);
        chk("rst_stat_ops", stat_ops, 16'd0);
        chk("rst_stat_wait", stat_wait, 16'd0);
        wait_cfg = 0;
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
